mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2, is the fixed memory read latency in cycles, from mem_en to mem_rdata valid; legal range 1..15.
REQ-002 Parameter AW, default 32, is the address width.
REQ-003 clk  input  1  single clock; all state is updated on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 if_req  input  1  fetch request; held high until if_gnt.
REQ-006 if_addr  input  AW  fetch word address.
REQ-007 if_gnt  output  1  fetch request accepted (1-cycle pulse).
REQ-008 if_rvalid  output  1  fetch read data valid (1-cycle pulse).
REQ-009 ls_req  input  1  load/store request; held high until ls_gnt.
REQ-010 ls_we  input  1  1 = store, 0 = load.
REQ-011 ls_addr  input  AW  load/store address.
REQ-012 ls_wdata  input  32  store data.
REQ-013 ls_be  input  4  store byte enables.
REQ-014 ls_gnt  output  1  load/store request accepted (1-cycle pulse).
REQ-015 ls_rvalid  output  1  load data valid or store acknowledged (1-cycle pulse).
REQ-016 rdata  output  32  shared read data; equals mem_rdata when if_rvalid or ls_rvalid is high, else 0.
REQ-017 mem_en, mem_we  output  1 each  memory strobe and write enable.
REQ-018 mem_addr, mem_wdata, mem_be  output  AW/32/4  memory address, write data and byte enables.
REQ-019 mem_rdata  input  32  memory read data.
REQ-020 busy  output  1  high when the state is not IDLE.
REQ-021 owner  output  2  current transaction owner: 00 NONE, 01 IF, 10 LS.

Function
REQ-022 The state machine has three states: IDLE, WAIT and RESP; at most one transaction is outstanding.
REQ-023 In IDLE, if any request is high in cycle T, the block asserts gnt, mem_en and the winner's address, data and enables combinationally in cycle T.
- mem_we = ls_we for an LS grant and 0 for an IF grant.
- mem_be = ls_be for an LS grant and 4'hF for an IF grant.
REQ-024 Arbitration is round-robin on a tie: the requester that was not the last owner wins; a sole requester always wins.
REQ-025 last_owner updates only on a grant.
REQ-026 On a grant, the owner is latched and cnt is loaded with MEM_LAT-1.
- Next state is RESP if MEM_LAT==1, otherwise WAIT.
REQ-027 In WAIT, cnt decrements each cycle; when cnt==1 the next state is RESP.
REQ-028 In RESP (cycle T+MEM_LAT), the owner's rvalid pulses for one cycle and the next state is IDLE.
- The earliest next grant is at T+MEM_LAT+1.
REQ-029 Stores produce an ls_rvalid acknowledge in the RESP cycle; rdata is still driven from mem_rdata and is ignored by the requester.
REQ-030 Requests arriving while busy are not granted and are not lost; they are served in IDLE under REQ-024.
REQ-031 Outside the grant cycle, mem_en, mem_we and mem_be are 0 and mem_addr and mem_wdata are 0.
REQ-032 A store with ls_be==0 is still issued and acknowledged.
REQ-033 An illegal state encoding forces the next state to IDLE.

Reset
REQ-034 While rst_n is low, all of the following hold:
- state = IDLE, owner = NONE, last_owner = LS (so IF wins the first tie), cnt = 0;
- every output is 0.
REQ-035 If rst_n falls mid-transaction, the transaction is aborted and no rvalid is produced after reset release.
REQ-036 The first grant is possible in the first clock edge cycle after rst_n rises.

Structure
REQ-037 The shared core package holds: owner_t (NONE/IF/LS), arb_state_t (IDLE/WAIT/RESP) and the MEM_LAT default constant.
REQ-038 The block is a single module with no sub-module; the round-robin pick is inline combinational logic.

Verification
REQ-039 MEM_LAT=2, single fetch: if_req with if_addr=0x100 at T gives if_gnt, mem_en and mem_addr=0x100 at T; if_rvalid at T+2 with rdata=mem_rdata=0xDEADBEEF.
REQ-040 Tie after reset: if_req and ls_req held from T gives IF granted at T and LS granted at T+3; repeating the tie gives IF next.
REQ-041 Store: ls_we=1, ls_addr=0x2000, ls_wdata=0x12345678, ls_be=4'b0011 gives mem_we=1 and mem_be=0011 at the grant, and ls_rvalid exactly MEM_LAT cycles later.
REQ-042 MEM_LAT=1, back-to-back fetches: grants at T, T+2, T+4; rvalid at T+1, T+3, T+5; busy high in each RESP cycle.
REQ-043 rst_n driven low at T+1 of a MEM_LAT=3 load: no ls_rvalid ever; after release, busy=0 and owner=00, and a new ls_req is granted.
REQ-044 ls_req raised while busy on an IF transaction: no ls_gnt until IDLE; ls_gnt occurs in the first IDLE cycle.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/load-store memory port arbiter.
//   owner_t     : transaction owner encoding (NONE/IF/LS), also the owner output value
//   arb_state_t : arbiter FSM state encoding
package mem_port_arbiter_pkg;

  localparam int unsigned MEM_LAT_DEFAULT = 2;
  localparam int unsigned CNT_W           = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_IF   = 2'b01,
    OWN_LS   = 2'b10
  } owner_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch / load-store requesters, the memory and the arbiter.
//   slave  : arbiter side (takes requests and mem_rdata, drives grants, rvalids, memory strobes)
//   master : requester/memory side (the opposite directions)
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 32
);

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;

  logic          ls_req;
  logic          ls_we;
  logic [AW-1:0] ls_addr;
  logic [31:0]   ls_wdata;
  logic [3:0]    ls_be;
  logic          ls_gnt;
  logic          ls_rvalid;

  logic [31:0]   rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic [31:0]   mem_rdata;

  logic          busy;
  logic [1:0]    owner;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_be, mem_rdata,
    output if_gnt, if_rvalid, ls_gnt, ls_rvalid, rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy, owner
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_be, mem_rdata,
    input  if_gnt, if_rvalid, ls_gnt, ls_rvalid, rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy, owner
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / load-store) arbiter onto a single fixed-latency memory port.
// One transaction outstanding at a time; round-robin on ties.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mem_port_arbiter_if.slave -- requests, grants, rvalids, shared rdata,
//                memory strobes, busy and owner status
// Grants and memory strobes are combinational in the IDLE cycle the request is seen;
// rvalid/busy/owner come straight from registered state.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MEM_LAT = MEM_LAT_DEFAULT,
  parameter int unsigned AW      = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus
);

  arb_state_t       state_q, state_d;
  owner_t           owner_q, owner_d;
  owner_t           last_q,  last_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             gnt_if_c;
  logic             gnt_ls_c;
  logic             resp_c;

  // State register; last owner resets to LS so IF wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_NONE;
      last_q  <= OWN_LS;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, round-robin pick and grant generation.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    gnt_if_c = 1'b0;
    gnt_ls_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // rst_n gate keeps grants and strobes low while reset is asserted.
        if (rst_n) begin
          if (bus.ls_req && (!bus.if_req || last_q == OWN_IF)) gnt_ls_c = 1'b1;
          else if (bus.if_req)                                 gnt_if_c = 1'b1;
        end
        if (gnt_if_c || gnt_ls_c) begin
          owner_d = gnt_ls_c ? OWN_LS : OWN_IF;
          last_d  = gnt_ls_c ? OWN_LS : OWN_IF;
          cnt_d   = CNT_W'(MEM_LAT - 1);
          state_d = (MEM_LAT == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  assign resp_c = (state_q == ST_RESP);

  // Memory strobes carry the winner's fields only in the grant cycle, else zero.
  assign bus.if_gnt    = gnt_if_c;
  assign bus.ls_gnt    = gnt_ls_c;
  assign bus.mem_en    = gnt_if_c | gnt_ls_c;
  assign bus.mem_we    = gnt_ls_c & bus.ls_we;
  assign bus.mem_be    = gnt_ls_c ? bus.ls_be : (gnt_if_c ? 4'hF : 4'h0);
  assign bus.mem_addr  = gnt_ls_c ? AW'(bus.ls_addr) : (gnt_if_c ? AW'(bus.if_addr) : '0);
  assign bus.mem_wdata = gnt_ls_c ? bus.ls_wdata : '0;

  assign bus.if_rvalid = resp_c && (owner_q == OWN_IF);
  assign bus.ls_rvalid = resp_c && (owner_q == OWN_LS);
  assign bus.rdata     = (bus.if_rvalid || bus.ls_rvalid) ? bus.mem_rdata : '0;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (MEM_LAT = 1, 2, 3) on a shared clock/reset.
// The MEM_LAT=2 instance is checked against a response scoreboard plus a vector table.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int unsigned AW   = 32;
  localparam int          LAT2 = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW)) b1 ();
  mem_port_arbiter_if #(.AW(AW)) b2 ();
  mem_port_arbiter_if #(.AW(AW)) b3 ();

  mem_port_arbiter #(.MEM_LAT(1), .AW(AW)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  mem_port_arbiter #(.MEM_LAT(2), .AW(AW)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
  mem_port_arbiter #(.MEM_LAT(3), .AW(AW)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Memory model data as a function of the address presented at mem_en.
  function automatic logic [31:0] mem_fn(logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0] ^ 16'hA5A5, a[31:16] ^ 16'h3C3C};
  endfunction

  logic [31:0] m2_addr = 32'h0;
  always @(posedge clk) if (b2.mem_en) m2_addr <= b2.mem_addr;
  assign b2.mem_rdata = mem_fn(m2_addr);
  assign b1.mem_rdata = 32'h10000000 | 32'(cyc);
  assign b3.mem_rdata = 32'h33333333;

  // Response scoreboard for the MEM_LAT=2 instance.
  typedef struct {
    bit          is_ls;
    int          cyc;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  function automatic void push(bit is_ls, int gcyc, logic [31:0] addr);
    exp_t e;
    e.is_ls = is_ls;
    e.cyc   = gcyc + LAT2;
    e.data  = mem_fn(addr);
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (b2.if_rvalid || b2.ls_rvalid) begin
        if (sb.size() == 0) begin
          check("u2 unexpected rvalid", 64'(1), 64'(0));
        end else begin
          e = sb.pop_front();
          check("u2 rvalid cycle", 64'(cyc), 64'(e.cyc));
          check("u2 ls_rvalid", 64'(b2.ls_rvalid), 64'(e.is_ls));
          check("u2 if_rvalid", 64'(b2.if_rvalid), 64'(!e.is_ls));
          check("u2 rdata", 64'(b2.rdata), 64'(e.data));
        end
      end else begin
        check("u2 rdata idle zero", 64'(b2.rdata), 64'(0));
      end
    end
  end

  int u3_rv_cnt = 0;
  always @(negedge clk) if (b3.ls_rvalid || b3.if_rvalid) u3_rv_cnt <= u3_rv_cnt + 1;

  typedef struct {
    bit          ifr, lsr, we;
    logic [3:0]  be;
    logic [31:0] addr, wdata;
    bit          eig, elg, ewe;
    logic [3:0]  ebe;
    logic [31:0] ewdata;
  } vec_t;
  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in the window right after an IF grant; LS request held, expected at first IDLE.
  task automatic ls_follow(string name, logic [31:0] addr);
    step();
    b2.if_req  = 1'b0;
    b2.ls_req  = 1'b1;
    b2.ls_addr = addr;
    #1;
    check({name, " ls_gnt wait"}, 64'(b2.ls_gnt), 64'(0));
    check({name, " busy wait"}, 64'(b2.busy), 64'(1));
    check({name, " owner if"}, 64'(b2.owner), 64'(OWN_IF));
    step();
    #1;
    check({name, " ls_gnt resp"}, 64'(b2.ls_gnt), 64'(0));
    check({name, " busy resp"}, 64'(b2.busy), 64'(1));
    step();
    #1;
    check({name, " ls_gnt idle"}, 64'(b2.ls_gnt), 64'(1));
    check({name, " ls mem_addr"}, 64'(b2.mem_addr), 64'(addr));
    push(1'b1, cyc, addr);
    step();
    b2.ls_req = 1'b0;
    step();
    step();
  endtask

  task automatic clear_bus2();
    b2.if_req = 1'b0; b2.if_addr = '0; b2.ls_req = 1'b0; b2.ls_we = 1'b0;
    b2.ls_addr = '0; b2.ls_wdata = '0; b2.ls_be = 4'h0;
  endtask

  initial begin
    int t0;
    int rv0;
    vecs[0] = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h100,      32'h11111111, 1'b1, 1'b0, 1'b0, 4'hF, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 4'hF, 32'h40,       32'hAAAA5555, 1'b0, 1'b1, 1'b0, 4'hF, 32'hAAAA5555};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 4'h3, 32'h2000,     32'h12345678, 1'b0, 1'b1, 1'b1, 4'h3, 32'h12345678};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 4'h0, 32'h3004,     32'hCAFE0000, 1'b0, 1'b1, 1'b1, 4'h0, 32'hCAFE0000};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 4'h6, 32'hFFFFFFFC, 32'h0BADF00D, 1'b1, 1'b0, 1'b0, 4'hF, 32'h0};
    vecs[5] = '{0,    1'b1, 1'b0, 4'hC, 32'h8,        32'h0,        1'b0, 1'b1, 1'b0, 4'hC, 32'h0};

    b1.if_req = 1'b0; b1.if_addr = '0; b1.ls_req = 1'b0; b1.ls_we = 1'b0;
    b1.ls_addr = '0; b1.ls_wdata = '0; b1.ls_be = 4'h0;
    b3.if_req = 1'b0; b3.if_addr = '0; b3.ls_req = 1'b0; b3.ls_we = 1'b0;
    b3.ls_addr = '0; b3.ls_wdata = '0; b3.ls_be = 4'h0;
    clear_bus2();

    // Outputs stay zero during reset even with both requests raised.
    b2.if_req = 1'b1; b2.ls_req = 1'b1; b2.if_addr = 32'h100; b2.ls_we = 1'b1; b2.ls_be = 4'hF;
    #2;
    check("rst if_gnt", 64'(b2.if_gnt), 64'(0));
    check("rst ls_gnt", 64'(b2.ls_gnt), 64'(0));
    check("rst mem_en", 64'(b2.mem_en), 64'(0));
    check("rst mem_addr", 64'(b2.mem_addr), 64'(0));
    check("rst mem_be", 64'(b2.mem_be), 64'(0));
    check("rst busy", 64'(b2.busy), 64'(0));
    check("rst owner", 64'(b2.owner), 64'(OWN_NONE));
    check("rst rdata", 64'(b2.rdata), 64'(0));
    step();
    step();
    clear_bus2();
    rst_n = 1'b1;

    // First tie after reset goes to IF, LS served at T+3; second tie goes to IF again.
    step();
    b2.if_req = 1'b1; b2.if_addr = 32'h100; b2.ls_req = 1'b1; b2.ls_addr = 32'h40; b2.ls_be = 4'hF;
    #1;
    t0 = cyc;
    check("tie1 if_gnt", 64'(b2.if_gnt), 64'(1));
    check("tie1 ls_gnt", 64'(b2.ls_gnt), 64'(0));
    check("tie1 mem_en", 64'(b2.mem_en), 64'(1));
    check("tie1 mem_addr", 64'(b2.mem_addr), 64'h100);
    push(1'b0, t0, 32'h100);
    ls_follow("tie1", 32'h40);
    b2.if_req = 1'b1; b2.ls_req = 1'b1; b2.ls_addr = 32'h48;
    #1;
    check("tie2 if_gnt", 64'(b2.if_gnt), 64'(1));
    check("tie2 ls_gnt", 64'(b2.ls_gnt), 64'(0));
    push(1'b0, cyc, 32'h100);
    ls_follow("tie2", 32'h48);

    // LS request raised only after the IF grant.
    b2.if_req = 1'b1; b2.if_addr = 32'h180;
    #1;
    check("late if_gnt", 64'(b2.if_gnt), 64'(1));
    push(1'b0, cyc, 32'h180);
    ls_follow("late", 32'h4C);

    // Table of single-requester transactions.
    for (int i = 0; i < 6; i++) begin
      step();
      b2.if_req   = vecs[i].ifr;
      b2.ls_req   = vecs[i].lsr;
      b2.ls_we    = vecs[i].we;
      b2.ls_be    = vecs[i].be;
      b2.ls_wdata = vecs[i].wdata;
      b2.if_addr  = vecs[i].ifr ? vecs[i].addr : ~vecs[i].addr;
      b2.ls_addr  = vecs[i].lsr ? vecs[i].addr : ~vecs[i].addr;
      #1;
      check($sformatf("vec%0d if_gnt", i), 64'(b2.if_gnt), 64'(vecs[i].eig));
      check($sformatf("vec%0d ls_gnt", i), 64'(b2.ls_gnt), 64'(vecs[i].elg));
      check($sformatf("vec%0d mem_en", i), 64'(b2.mem_en), 64'(1));
      check($sformatf("vec%0d mem_we", i), 64'(b2.mem_we), 64'(vecs[i].ewe));
      check($sformatf("vec%0d mem_be", i), 64'(b2.mem_be), 64'(vecs[i].ebe));
      check($sformatf("vec%0d mem_addr", i), 64'(b2.mem_addr), 64'(vecs[i].addr));
      check($sformatf("vec%0d mem_wdata", i), 64'(b2.mem_wdata), 64'(vecs[i].ewdata));
      push(vecs[i].elg, cyc, vecs[i].addr);
      step();
      b2.if_req = 1'b0;
      b2.ls_req = 1'b0;
      #1;
      check($sformatf("vec%0d busy", i), 64'(b2.busy), 64'(1));
      check($sformatf("vec%0d owner", i), 64'(b2.owner), vecs[i].elg ? 64'(OWN_LS) : 64'(OWN_IF));
      check($sformatf("vec%0d mem_en off", i), 64'(b2.mem_en), 64'(0));
      check($sformatf("vec%0d mem_addr off", i), 64'(b2.mem_addr), 64'(0));
      check($sformatf("vec%0d mem_wdata off", i), 64'(b2.mem_wdata), 64'(0));
      step();
      #1;
      check($sformatf("vec%0d busy resp", i), 64'(b2.busy), 64'(1));
      check($sformatf("vec%0d mem_be off", i), 64'(b2.mem_be), 64'(0));
      step();
      #1;
      check($sformatf("vec%0d busy idle", i), 64'(b2.busy), 64'(0));
      check($sformatf("vec%0d owner idle", i), 64'(b2.owner), 64'(OWN_NONE));
    end

    // MEM_LAT=1: fetch held high, grants every other cycle.
    step();
    b1.if_req  = 1'b1;
    b1.if_addr = 32'h500;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("lat1 c%0d if_gnt", i), 64'(b1.if_gnt), 64'(i % 2 == 0));
      check($sformatf("lat1 c%0d if_rvalid", i), 64'(b1.if_rvalid), 64'(i % 2 == 1));
      check($sformatf("lat1 c%0d busy", i), 64'(b1.busy), 64'(i % 2 == 1));
      check($sformatf("lat1 c%0d rdata", i), 64'(b1.rdata), (i % 2 == 1) ? 64'(b1.mem_rdata) : 64'(0));
      if (i % 2 == 0) check($sformatf("lat1 c%0d mem_addr", i), 64'(b1.mem_addr), 64'(32'h500 + 32'(4 * (i / 2))));
      else b1.if_addr = b1.if_addr + 32'h4;
      step();
    end
    b1.if_req = 1'b0;

    // MEM_LAT=3 load aborted by reset one cycle after its grant.
    step();
    b3.ls_req = 1'b1; b3.ls_addr = 32'h700; b3.ls_be = 4'hF;
    #1;
    check("abort ls_gnt", 64'(b3.ls_gnt), 64'(1));
    rv0 = u3_rv_cnt;
    step();
    b3.ls_req = 1'b0;
    b3.if_req = 1'b1;
    rst_n     = 1'b0;
    #1;
    check("abort rst busy", 64'(b3.busy), 64'(0));
    check("abort rst owner", 64'(b3.owner), 64'(OWN_NONE));
    check("abort rst if_gnt", 64'(b3.if_gnt), 64'(0));
    check("abort rst mem_en", 64'(b3.mem_en), 64'(0));
    step();
    step();
    b3.if_req  = 1'b0;
    rst_n      = 1'b1;
    b1.if_req  = 1'b1;
    b1.if_addr = 32'h900;
    #1;
    check("post rst first if_gnt", 64'(b1.if_gnt), 64'(1));
    check("post rst first mem_addr", 64'(b1.mem_addr), 64'h900);
    check("post rst u3 busy", 64'(b3.busy), 64'(0));
    check("post rst u3 owner", 64'(b3.owner), 64'(OWN_NONE));
    step();
    b1.if_req = 1'b0;
    #1;
    check("post rst first if_rvalid", 64'(b1.if_rvalid), 64'(1));
    step();
    step();
    step();
    #1;
    check("abort no rvalid", 64'(u3_rv_cnt), 64'(rv0));
    b3.ls_req = 1'b1; b3.ls_addr = 32'h704;
    #1;
    check("post abort ls_gnt", 64'(b3.ls_gnt), 64'(1));
    step();
    b3.ls_req = 1'b0;
    step();
    #1;
    check("post abort rvalid early", 64'(b3.ls_rvalid), 64'(0));
    step();
    #1;
    check("post abort ls_rvalid", 64'(b3.ls_rvalid), 64'(1));
    check("post abort rdata", 64'(b3.rdata), 64'h33333333);
    step();
    step();

    check("scoreboard drained", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
